adc_par_capture: RTL

- Multi-channel parallel-ADC capture front end, successor to the single-channel AD9226 interface.
- Detects falling edges of the ADC sample clock in the system clock domain and latches NUM_CH parallel ADC words after a fixed settle delay.
- Drops the first DISCARD_CNT conversions after enable, then applies per-channel offset subtraction with saturation.
- Buffers frames in a FIFO and presents them on an AXI-Stream master port with backpressure and overflow accounting.

---
 rtl/adc_par_capture.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/adc_par_capture.sv
// Multi-channel parallel-ADC capture front end. It latches NUM_CH ADC words on
// falling edges of clk_sample, discards the start-up conversions, applies a
// saturating offset subtraction and streams the frames out through a FIFO on AXI-Stream.
module adc_par_capture #(
   parameter int ADC_DATA_WIDTH = 12,
   parameter int NUM_CH         = 2,
   parameter int DISCARD_CNT    = 4,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clk_sample,
   input  logic                             ready,
   input  logic [NUM_CH*ADC_DATA_WIDTH-1:0] data_in,
   input  logic                             cfg_enable,
   input  logic                             cfg_offset_en,
   input  logic [NUM_CH*ADC_DATA_WIDTH-1:0] cfg_offset,
   input  logic                             cfg_clear_ovf,
   output logic [NUM_CH*ADC_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tuser,
   output logic                             eoc,
   output logic                             ovf_flag,
   output logic [15:0]                      ovf_count
);

   localparam int W   = ADC_DATA_WIDTH;
   localparam int DW  = NUM_CH * W;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DCW = (DISCARD_CNT > 0) ? $clog2(DISCARD_CNT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LOW,
      ACQ,
      HOLD,
      WAIT_HIGH
   } state_t;

   state_t           state;
   logic             s1, s2, s3;
   logic             fall;
   logic [DCW-1:0]   disc_cnt;
   logic [DW-1:0]    raw_data;
   logic             raw_ready;
   logic             lat_valid;
   logic [DW-1:0]    proc_data;

   logic [DW:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      mem_cnt;
   logic             full, pop, load, wr_en, drop;

   // Subtract as a (W+1)-bit two's-complement value; overflow into the top
   // bit pair means the result left the signed W-bit range.
   function automatic logic [W-1:0] offset_sat(input logic [W-1:0] raw, input logic [W-1:0] off);
      logic [W:0] diff;
      diff = {1'b0, raw} - {1'b0, off};
      if (diff[W] != diff[W-1])
         offset_sat = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         offset_sat = diff[W-1:0];
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values and the synchronizer chain shifts by exactly one stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_sample;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall = s3 & ~s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         disc_cnt  <= DCW'(DISCARD_CNT);
         raw_data  <= '0;
         raw_ready <= 1'b0;
         lat_valid <= 1'b0;
      end else begin
         lat_valid <= 1'b0;
         if (!cfg_enable) begin
            state    <= IDLE;
            disc_cnt <= DCW'(DISCARD_CNT);
         end else begin
            case (state)
               IDLE:      state <= WAIT_LOW;
               WAIT_LOW:  if (fall) state <= ACQ;
               ACQ:       state <= HOLD;
               HOLD: begin
                  raw_data  <= data_in;
                  raw_ready <= ready;
                  if (disc_cnt != '0) disc_cnt  <= disc_cnt - 1'b1;
                  else                lat_valid <= 1'b1;
                  state <= WAIT_HIGH;
               end
               WAIT_HIGH: if (s2) state <= WAIT_LOW;
               default:   state <= IDLE;
            endcase
         end
      end
   end

   // NOTE: every variable driven here gets a default first, so no latch is inferred.
   always_comb begin
      proc_data = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (!raw_ready)
            proc_data[ch*W +: W] = '0;
         else if (cfg_offset_en)
            proc_data[ch*W +: W] = offset_sat(raw_data[ch*W +: W], cfg_offset[ch*W +: W]);
         else
            proc_data[ch*W +: W] = raw_data[ch*W +: W];
      end
   end

   // The output register counts toward capacity, so total storage is FIFO_DEPTH.
   assign full  = (mem_cnt + {{AW{1'b0}}, m_axis_tvalid}) == (AW+1)'(FIFO_DEPTH);
   assign pop   = m_axis_tvalid & m_axis_tready;
   assign load  = (mem_cnt != '0) & (~m_axis_tvalid | m_axis_tready);
   assign wr_en = lat_valid & (~full | pop);
   assign drop  = lat_valid & full & ~pop;

   // NOTE: the frame memory has no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {~raw_ready, proc_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         mem_cnt       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         eoc           <= 1'b0;
         ovf_flag      <= 1'b0;
         ovf_count     <= '0;
      end else begin
         eoc <= wr_en;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr        <= rd_ptr + 1'b1;
            m_axis_tvalid <= 1'b1;
            {m_axis_tuser, m_axis_tdata} <= mem[rd_ptr];
         end else if (pop) begin
            m_axis_tvalid <= 1'b0;
         end
         case ({wr_en, load})
            2'b10:   mem_cnt <= mem_cnt + 1'b1;
            2'b01:   mem_cnt <= mem_cnt - 1'b1;
            default: mem_cnt <= mem_cnt;
         endcase
         if (cfg_clear_ovf) begin
            ovf_flag  <= drop;
            ovf_count <= drop ? 16'd1 : 16'd0;
         end else if (drop) begin
            ovf_flag <= 1'b1;
            if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
         end
      end
   end

endmodule
